// File: rtl/gfx_scanline_buffer_pkg.sv
// ---------------------------------------------------------------------------
// gfx_scanline_buffer_pkg
// Shared definitions for the scanline double buffer: per-bank state
// encoding, GBA line geometry constants and the stored color type.
// No ports (package).
// ---------------------------------------------------------------------------
package gfx_scanline_buffer_pkg;

    localparam int GBA_LINE_W = 240;
    localparam int GBA_LINES  = 160;
    localparam int GBA_COLOR_W = 15;

    typedef logic [GBA_COLOR_W-1:0] color15_t;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_state_t;

    // A bank holds a complete line that the scanout side may read.
    function automatic logic bank_readable(input bank_state_t s);
        return (s == FULL) || (s == DRAINING);
    endfunction

endpackage

// File: rtl/gfx_line_bank.sv
// ---------------------------------------------------------------------------
// gfx_line_bank
// One scanline of pixel storage: a synchronous write port and an
// asynchronous (combinational) read port.
//
// Ports:
//   clock    system clock
//   wr_en    write strobe
//   wr_addr  pixel index to write
//   wr_data  pixel color to write
//   rd_addr  pixel index to read
//   rd_data  pixel color at rd_addr (combinational)
// ---------------------------------------------------------------------------
module gfx_line_bank
    import gfx_scanline_buffer_pkg::*;
#(
    parameter int DEPTH  = GBA_LINE_W,
    parameter int WIDTH  = GBA_COLOR_W,
    parameter int ADDR_W = 8
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Contents are never reset; the controller tracks validity per bank.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/gfx_scanline_buffer.sv
// ---------------------------------------------------------------------------
// gfx_scanline_buffer
// Double-buffered scanline store between the graphics pipeline output and
// the display scanout. One bank captures the incoming line while the other
// drains over a valid/ready stream. Dropped lines (no empty bank) and lines
// cut short by an early line start are reported through sticky flags.
//
// Ports:
//   clock          system clock
//   rst_b          synchronous active-low reset
//   in_line_start  new line begins (may carry pixel 0 in the same cycle)
//   in_row         line number, sampled with in_line_start
//   in_valid       pixel strobe
//   in_color       pixel color, bit 15 ignored
//   out_valid      pixel available to scanout
//   out_ready      scanout accepts the pixel
//   out_color      pixel color
//   out_x          pixel index within the line
//   out_row        row tag of the draining line
//   out_last       current pixel is the last of the line
//   clear_status   clears the sticky flags
//   overflow       sticky: a line was dropped for lack of an empty bank
//   short_line     sticky: a line was aborted before it was complete
//
// Per-bank state:
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   EMPTY    | no content, may accept a new line
//   FILLING  | capturing pixels of the current input line
//   FULL     | complete line stored, nothing sent yet
//   DRAINING | at least one pixel of the line has been sent
// ---------------------------------------------------------------------------
module gfx_scanline_buffer
    import gfx_scanline_buffer_pkg::*;
#(
    parameter int LINE_W  = GBA_LINE_W,
    parameter int COLOR_W = GBA_COLOR_W,
    parameter int X_W     = 8,
    parameter int ROW_W   = 8
) (
    input  logic               clock,
    input  logic               rst_b,
    input  logic               in_line_start,
    input  logic [ROW_W-1:0]   in_row,
    input  logic               in_valid,
    input  logic [15:0]        in_color,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COLOR_W-1:0] out_color,
    output logic [X_W-1:0]     out_x,
    output logic [ROW_W-1:0]   out_row,
    output logic               out_last,
    input  logic               clear_status,
    output logic               overflow,
    output logic               short_line
);

    localparam logic [X_W-1:0] LAST_X = X_W'(LINE_W - 1);

    bank_state_t      bank_st   [2];
    bank_state_t      bank_st_n [2];
    logic [ROW_W-1:0] row_tag   [2];
    logic [ROW_W-1:0] row_tag_n [2];

    logic             wr_bank, wr_bank_n;
    logic             rd_bank, rd_bank_n;
    logic [X_W-1:0]   wr_x, wr_x_n;
    logic [X_W-1:0]   rd_x, rd_x_n;
    logic             overflow_n, short_line_n;

    logic             xfer;
    logic             wr_en;
    logic [X_W-1:0]   wr_addr;
    bank_state_t      wr_state;

    logic [COLOR_W-1:0] wr_data;
    logic [COLOR_W-1:0] rd_data [2];

    logic unused_color_msb;
    assign unused_color_msb = in_color[15];
    assign wr_data          = in_color[COLOR_W-1:0];

    // -----------------------------------------------------------------------
    // Storage
    // -----------------------------------------------------------------------
    gfx_line_bank #(
        .DEPTH  (LINE_W),
        .WIDTH  (COLOR_W),
        .ADDR_W (X_W)
    ) u_bank0 (
        .clock   (clock),
        .wr_en   (wr_en && !wr_bank),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_x),
        .rd_data (rd_data[0])
    );

    gfx_line_bank #(
        .DEPTH  (LINE_W),
        .WIDTH  (COLOR_W),
        .ADDR_W (X_W)
    ) u_bank1 (
        .clock   (clock),
        .wr_en   (wr_en && wr_bank),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_x),
        .rd_data (rd_data[1])
    );

    // -----------------------------------------------------------------------
    // Scanout side outputs
    // -----------------------------------------------------------------------
    assign out_valid = bank_readable(bank_st[rd_bank]);
    assign xfer      = out_valid && out_ready;
    assign out_x     = rd_x;
    assign out_row   = row_tag[rd_bank];
    assign out_last  = out_valid && (rd_x == LAST_X);
    // Gated so that uninitialised storage never reaches the port.
    assign out_color = out_valid ? rd_data[rd_bank] : '0;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!rst_b) begin
            bank_st[0] <= EMPTY;
            bank_st[1] <= EMPTY;
            row_tag[0] <= '0;
            row_tag[1] <= '0;
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            wr_x       <= '0;
            rd_x       <= '0;
            overflow   <= 1'b0;
            short_line <= 1'b0;
        end else begin
            bank_st[0] <= bank_st_n[0];
            bank_st[1] <= bank_st_n[1];
            row_tag[0] <= row_tag_n[0];
            row_tag[1] <= row_tag_n[1];
            wr_bank    <= wr_bank_n;
            rd_bank    <= rd_bank_n;
            wr_x       <= wr_x_n;
            rd_x       <= rd_x_n;
            overflow   <= overflow_n;
            short_line <= short_line_n;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic. The read side is evaluated first so that a bank
    // finishing its drain this cycle is already seen as EMPTY by the write
    // side (lets a new line land in it without a bubble).
    // -----------------------------------------------------------------------
    always_comb begin
        bank_st_n[0] = bank_st[0];
        bank_st_n[1] = bank_st[1];
        row_tag_n[0] = row_tag[0];
        row_tag_n[1] = row_tag[1];
        wr_bank_n    = wr_bank;
        rd_bank_n    = rd_bank;
        wr_x_n       = wr_x;
        rd_x_n       = rd_x;
        // Clear first; any event this cycle sets the flag again below.
        overflow_n   = overflow && !clear_status;
        short_line_n = short_line && !clear_status;
        wr_en        = 1'b0;
        wr_addr      = wr_x;
        wr_state     = EMPTY;

        if (xfer) begin
            if (rd_x == LAST_X) begin
                bank_st_n[rd_bank] = EMPTY;
                rd_x_n             = '0;
                rd_bank_n          = !rd_bank;
            end else begin
                bank_st_n[rd_bank] = DRAINING;
                rd_x_n             = rd_x + 1'b1;
            end
        end

        wr_state = bank_st_n[wr_bank];

        if (in_line_start) begin
            // An unfinished line is abandoned; its bank is reused at once.
            if (wr_state == FILLING) begin
                short_line_n = 1'b1;
                wr_state     = EMPTY;
            end
            if (wr_state == EMPTY) begin
                bank_st_n[wr_bank] = FILLING;
                row_tag_n[wr_bank] = in_row;
                wr_x_n             = '0;
                wr_addr            = '0;
                wr_state           = FILLING;
            end else begin
                overflow_n = 1'b1;
            end
        end

        if (in_valid && (wr_state == FILLING)) begin
            wr_en = 1'b1;
            if (wr_addr == LAST_X) begin
                bank_st_n[wr_bank] = FULL;
                wr_bank_n          = !wr_bank;
                wr_x_n             = '0;
            end else begin
                wr_x_n = wr_addr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gfx_scanline_buffer.sv
// ---------------------------------------------------------------------------
// tb_gfx_scanline_buffer
// Directed self-checking bench for gfx_scanline_buffer. Inputs are driven
// and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_gfx_scanline_buffer;

    logic        clock = 1'b0;
    logic        rst_b;
    logic        in_line_start;
    logic [7:0]  in_row;
    logic        in_valid;
    logic [15:0] in_color;
    logic        out_valid;
    logic        out_ready;
    logic [14:0] out_color;
    logic [7:0]  out_x;
    logic [7:0]  out_row;
    logic        out_last;
    logic        clear_status;
    logic        overflow;
    logic        short_line;

    int n_checks = 0;
    int n_fail   = 0;

    gfx_scanline_buffer dut (
        .clock         (clock),
        .rst_b         (rst_b),
        .in_line_start (in_line_start),
        .in_row        (in_row),
        .in_valid      (in_valid),
        .in_color      (in_color),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_color     (out_color),
        .out_x         (out_x),
        .out_row       (out_row),
        .out_last      (out_last),
        .clear_status  (clear_status),
        .overflow      (overflow),
        .short_line    (short_line)
    );

    always #5 clock = ~clock;

    // Feeds one line of npix pixels back to back, pixel 0 together with the
    // line start. Color = {tag[6:0], x}; bit 15 is set to show it is dropped.
    task automatic write_line(input logic [7:0] row, input int npix, input logic [7:0] tag);
        for (int i = 0; i < npix; i++) begin
            @(negedge clock);
            in_line_start = (i == 0);
            in_row        = row;
            in_valid      = 1'b1;
            in_color      = {1'b1, tag[6:0], 8'(i)};
        end
        @(negedge clock);
        in_line_start = 1'b0;
        in_valid      = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_status = 1'b1;
        @(negedge clock);
        clear_status = 1'b0;
    endtask

    task automatic test_reset();
        rst_b = 1'b0; in_line_start = 1'b0; in_row = '0; in_valid = 1'b0;
        in_color = '0; out_ready = 1'b0; clear_status = 1'b0;
        repeat (2) @(negedge clock);
        n_checks++;
        if ({out_valid, out_last, overflow, short_line, out_x, out_row, out_color} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got v=%b l=%b ovf=%b sh=%b x=%0d row=%0d col=%h want all 0",
                     out_valid, out_last, overflow, short_line, out_x, out_row, out_color);
        end
        rst_b = 1'b1;
        // Pixels before any line start are ignored.
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_color = 16'(i);
            @(negedge clock);
        end
        in_valid = 1'b0;
        repeat (2) @(negedge clock);
        n_checks++;
        if (out_valid !== 1'b0 || overflow !== 1'b0 || short_line !== 1'b0) begin
            n_fail++;
            $display("FAIL stray_pixels got v=%b ovf=%b sh=%b want 0 0 0", out_valid, overflow, short_line);
        end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        for (int i = 0; i < 240; i++) begin
            @(negedge clock);
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_fill_valid at pixel %0d got %b want 0", i, out_valid);
            end
            in_line_start = (i == 0); in_row = 8'd5; in_valid = 1'b1;
            in_color = {1'b1, 7'd0, 8'(i)};
        end
        @(negedge clock);
        in_line_start = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 240; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_x !== 8'(i) || out_row !== 8'd5 ||
                out_color !== 15'(i) || out_last !== (i == 239)) begin
                n_fail++;
                $display("FAIL basic_drain i=%0d got v=%b x=%0d row=%0d col=%h last=%b want 1 %0d 5 %h %b",
                         i, out_valid, out_x, out_row, out_color, out_last, i, 15'(i), (i == 239));
            end
            @(negedge clock);
        end
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_end_valid got %b want 0", out_valid);
        end
    endtask

    task automatic test_stall();
        int exp_x = 0;
        int cyc = 0;
        out_ready = 1'b0;
        write_line(8'd7, 240, 8'd7);
        while (exp_x < 240 && cyc < 1000) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_x !== exp_x[7:0] || out_row !== 8'd7 ||
                out_color !== {7'd7, exp_x[7:0]} || out_last !== (exp_x == 239)) begin
                n_fail++;
                $display("FAIL stall_drain cyc=%0d got v=%b x=%0d row=%0d col=%h last=%b want 1 %0d 7 %h %b",
                         cyc, out_valid, out_x, out_row, out_color, out_last, exp_x,
                         {7'd7, exp_x[7:0]}, (exp_x == 239));
            end
            out_ready = (cyc % 3 != 0);
            if (out_ready) exp_x++;
            cyc++;
            @(negedge clock);
        end
        n_checks++;
        if (exp_x != 240 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_end got transfers=%0d v=%b want 240 0", exp_x, out_valid);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] r;
        out_ready = 1'b0;
        write_line(8'd1, 240, 8'd1);
        write_line(8'd2, 240, 8'd2);
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_two_lines got %b want 0", overflow);
        end
        write_line(8'd3, 240, 8'd3);
        n_checks++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_third_line got %b want 1", overflow);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 480; i++) begin
            r = (i < 240) ? 8'd1 : 8'd2;
            n_checks++;
            if (out_valid !== 1'b1 || out_row !== r || out_x !== 8'(i % 240) ||
                out_color !== {r[6:0], 8'(i % 240)}) begin
                n_fail++;
                $display("FAIL ovf_drain i=%0d got v=%b row=%0d x=%0d col=%h want 1 %0d %0d %h",
                         i, out_valid, out_row, out_x, out_color, r, i % 240, {r[6:0], 8'(i % 240)});
            end
            @(negedge clock);
        end
        n_checks++;
        if (out_valid !== 1'b0 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_after_drain got v=%b ovf=%b want 0 1", out_valid, overflow);
        end
        pulse_clear();
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear got %b want 0", overflow);
        end
    endtask

    task automatic test_short_line();
        out_ready = 1'b0;
        write_line(8'd8, 100, 8'd8);
        n_checks++;
        if (short_line !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL short_partial got sh=%b v=%b want 0 0", short_line, out_valid);
        end
        write_line(8'd9, 240, 8'd9);
        n_checks++;
        if (short_line !== 1'b1) begin
            n_fail++;
            $display("FAIL short_flag got %b want 1", short_line);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 240; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_row !== 8'd9 || out_x !== 8'(i) ||
                out_color !== {7'd9, 8'(i)}) begin
                n_fail++;
                $display("FAIL short_drain i=%0d got v=%b row=%0d x=%0d col=%h want 1 9 %0d %h",
                         i, out_valid, out_row, out_x, out_color, i, {7'd9, 8'(i)});
            end
            @(negedge clock);
        end
        n_checks++;
        if (out_valid !== 1'b0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL short_end got v=%b ovf=%b want 0 0", out_valid, overflow);
        end
        pulse_clear();
        n_checks++;
        if (short_line !== 1'b0) begin
            n_fail++;
            $display("FAIL short_clear got %b want 0", short_line);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] r;
        out_ready = 1'b0;
        write_line(8'd20, 240, 8'd20);
        write_line(8'd21, 240, 8'd21);
        out_ready = 1'b1;
        // Line 22 starts in the same cycle that row 20 sends its last pixel.
        for (int j = 0; j < 720; j++) begin
            r = (j < 240) ? 8'd20 : ((j < 480) ? 8'd21 : 8'd22);
            n_checks++;
            if (out_valid !== 1'b1 || out_row !== r || out_x !== 8'(j % 240) ||
                out_color !== {r[6:0], 8'(j % 240)}) begin
                n_fail++;
                $display("FAIL b2b_drain j=%0d got v=%b row=%0d x=%0d col=%h want 1 %0d %0d %h",
                         j, out_valid, out_row, out_x, out_color, r, j % 240, {r[6:0], 8'(j % 240)});
            end
            if (j >= 239 && j < 479) begin
                in_line_start = (j == 239); in_row = 8'd22; in_valid = 1'b1;
                in_color = {1'b1, 7'd22, 8'(j - 239)};
            end else begin
                in_line_start = 1'b0; in_valid = 1'b0;
            end
            @(negedge clock);
        end
        n_checks++;
        if (out_valid !== 1'b0 || overflow !== 1'b0 || short_line !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_end got v=%b ovf=%b sh=%b want 0 0 0", out_valid, overflow, short_line);
        end
    endtask

    task automatic test_reset_mid_drain();
        out_ready = 1'b0;
        write_line(8'd30, 240, 8'd30);
        write_line(8'd31, 10, 8'd31);
        write_line(8'd32, 5, 8'd32);
        n_checks++;
        if (short_line !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_setup_short got %b want 1", short_line);
        end
        out_ready = 1'b1;
        repeat (50) @(negedge clock);
        n_checks++;
        if (out_valid !== 1'b1 || out_x !== 8'd50 || out_row !== 8'd30) begin
            n_fail++;
            $display("FAIL rstmid_pos got v=%b x=%0d row=%0d want 1 50 30", out_valid, out_x, out_row);
        end
        rst_b = 1'b0;
        @(negedge clock);
        rst_b = 1'b1;
        out_ready = 1'b0;
        n_checks++;
        if ({out_valid, out_last, overflow, short_line, out_x, out_row, out_color} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_outputs got v=%b l=%b ovf=%b sh=%b x=%0d row=%0d col=%h want all 0",
                     out_valid, out_last, overflow, short_line, out_x, out_row, out_color);
        end
        write_line(8'd40, 240, 8'd40);
        out_ready = 1'b1;
        for (int i = 0; i < 240; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_row !== 8'd40 || out_x !== 8'(i) ||
                out_color !== {7'd40, 8'(i)}) begin
                n_fail++;
                $display("FAIL rstmid_drain i=%0d got v=%b row=%0d x=%0d col=%h want 1 40 %0d %h",
                         i, out_valid, out_row, out_x, out_color, i, {7'd40, 8'(i)});
            end
            @(negedge clock);
        end
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_end_valid got %b want 0", out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_overflow();
        test_short_line();
        test_back_to_back();
        test_reset_mid_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout simulation exceeded time limit got running want finished");
        $fatal(1, "timeout");
    end

endmodule
